// File: rtl/nx_arb_pkg.sv
// Shared types for the node stream arbiter and its picker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Direction encoding is fixed: N=0, E=1, S=2, W=3. Any block that carries a
// direction tag should use nx_direction_t so the encoding stays consistent.
package nx_arb_pkg;

   localparam int NX_NUM_DIRS = 4;

   typedef enum logic [1:0] {
      NX_DIR_NORTH = 2'd0,
      NX_DIR_EAST  = 2'd1,
      NX_DIR_SOUTH = 2'd2,
      NX_DIR_WEST  = 2'd3
   } nx_direction_t;

endpackage

// File: rtl/nx_arb_rr_pick.sv
// Combinational 4-way round-robin picker.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports:
//   req   in  4  request vector, bit i = direction i
//   last  in  2  index of the most recently served direction
//   grant out 4  one-hot grant (all zero when no request)
//   idx   out 2  encoded index of the granted direction (0 when none)
//   any   out 1  at least one request present
//
// Search starts at last+1 and wraps, so the direction served last has the
// lowest priority. Kept free of state so the outbound distributor can reuse it.
module nx_rr_pick
   import nx_arb_pkg::*;
(
   input  logic [NX_NUM_DIRS-1:0] req,
   input  logic [1:0]             last,
   output logic [NX_NUM_DIRS-1:0] grant,
   output logic [1:0]             idx,
   output logic                   any
);

   logic [1:0] cand;
   logic       found;

   always_comb begin
      grant = '0;
      idx   = 2'd0;
      cand  = 2'd0;
      found = 1'b0;
      // i = 4 wraps cand back to last itself, giving it lowest priority.
      for (int i = 1; i <= NX_NUM_DIRS; i++) begin
         cand = last + 2'(i);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/nx_stream_arbiter.sv
// Round-robin merge of the four inbound node streams into one registered stream.
// Latency: 1 cycle from inbound handshake to arb_valid_o; 1 message/cycle peak.
// Backpressure: when the output slot is full and arb_ready_i=0, all inbound readies are 0.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   ib_<dir>_data_i/_valid_i        inbound message and valid, dir = north/east/south/west
//   ib_<dir>_ready_o                inbound ready (granted and slot can take a word)
//   arb_data_o, arb_dir_o           registered message and its source direction
//   arb_valid_o, arb_ready_i        output valid/ready
//   idle_o                          no inbound valid and output slot empty
//   stat_count_o                    per-direction accepted counts, N in LSB slice
//                                   (only when NX_ARB_STATS_EN is defined)
//
// Optional feature macro: NX_ARB_STATS_EN (saturating per-direction counters).
module nx_stream_arbiter
   import nx_arb_pkg::*;
#(
   parameter int STREAM_WIDTH = 32,
   parameter int NUM_DIRS     = 4,
   parameter int COUNT_WIDTH  = 16
)
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [STREAM_WIDTH-1:0] ib_north_data_i,
   input  logic                    ib_north_valid_i,
   output logic                    ib_north_ready_o,
   input  logic [STREAM_WIDTH-1:0] ib_east_data_i,
   input  logic                    ib_east_valid_i,
   output logic                    ib_east_ready_o,
   input  logic [STREAM_WIDTH-1:0] ib_south_data_i,
   input  logic                    ib_south_valid_i,
   output logic                    ib_south_ready_o,
   input  logic [STREAM_WIDTH-1:0] ib_west_data_i,
   input  logic                    ib_west_valid_i,
   output logic                    ib_west_ready_o,
   output logic [STREAM_WIDTH-1:0] arb_data_o,
   output nx_direction_t           arb_dir_o,
   output logic                    arb_valid_o,
   input  logic                    arb_ready_i,
   output logic                    idle_o
`ifdef NX_ARB_STATS_EN
   ,
   output logic [NUM_DIRS*COUNT_WIDTH-1:0] stat_count_o
`endif
);

   logic [NUM_DIRS-1:0]     req;
   logic [NUM_DIRS-1:0]     grant;
   logic [1:0]              grant_idx;
   logic                    any_req;
   logic [1:0]              last_q;
   logic                    slot_free;
   logic                    accept;
   logic [STREAM_WIDTH-1:0] sel_data;

   assign req = {ib_west_valid_i, ib_south_valid_i, ib_east_valid_i, ib_north_valid_i};

   nx_rr_pick u_pick (
      .req   (req),
      .last  (last_q),
      .grant (grant),
      .idx   (grant_idx),
      .any   (any_req)
   );

   // The slot can take a word when empty or when it drains this same cycle.
   assign slot_free = !arb_valid_o || arb_ready_i;

   // rst_i gates readies directly so they drop without waiting for an edge.
   assign ib_north_ready_o = grant[0] & slot_free & ~rst_i;
   assign ib_east_ready_o  = grant[1] & slot_free & ~rst_i;
   assign ib_south_ready_o = grant[2] & slot_free & ~rst_i;
   assign ib_west_ready_o  = grant[3] & slot_free & ~rst_i;

   // A grant only exists for a valid requester, so grant+slot_free is the handshake.
   assign accept = (|grant) && slot_free;

   always_comb begin
      sel_data = ib_north_data_i;
      case (grant_idx)
         2'd0:    sel_data = ib_north_data_i;
         2'd1:    sel_data = ib_east_data_i;
         2'd2:    sel_data = ib_south_data_i;
         default: sel_data = ib_west_data_i;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         arb_valid_o <= 1'b0;
         arb_data_o  <= '0;
         arb_dir_o   <= NX_DIR_NORTH;
         last_q      <= 2'd3;   // W served "last" so N wins first after reset
      end else if (accept) begin
         arb_valid_o <= 1'b1;
         arb_data_o  <= sel_data;
         arb_dir_o   <= nx_direction_t'(grant_idx);
         last_q      <= grant_idx;
      end else if (arb_ready_i) begin
         // Drain with no refill; data/dir deliberately hold their last value.
         arb_valid_o <= 1'b0;
      end
   end

   assign idle_o = !arb_valid_o && !any_req;

`ifdef NX_ARB_STATS_EN
   logic [COUNT_WIDTH-1:0] stat_q [NUM_DIRS];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int d = 0; d < NUM_DIRS; d++) begin
            stat_q[d] <= '0;
         end
      end else begin
         for (int d = 0; d < NUM_DIRS; d++) begin
            // Saturate rather than wrap so a long run never reads as a small count.
            if (accept && grant[d] && (stat_q[d] != {COUNT_WIDTH{1'b1}})) begin
               stat_q[d] <= stat_q[d] + COUNT_WIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      stat_count_o = '0;
      for (int d = 0; d < NUM_DIRS; d++) begin
         stat_count_o[d*COUNT_WIDTH +: COUNT_WIDTH] = stat_q[d];
      end
   end
`endif

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Directed self-checking bench for nx_stream_arbiter.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Stats checks run only when NX_ARB_STATS_EN is defined.
module tb_nx_stream_arbiter;
   import nx_arb_pkg::*;

   localparam int SW = 32;
   localparam int CW = 2;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [SW-1:0] n_d, e_d, s_d, w_d;
   logic          n_v, e_v, s_v, w_v;
   logic          n_r, e_r, s_r, w_r;
   logic [SW-1:0] arb_data_o;
   nx_direction_t arb_dir_o;
   logic          arb_valid_o;
   logic          arb_ready_i;
   logic          idle_o;
`ifdef NX_ARB_STATS_EN
   logic [4*CW-1:0] stat_count_o;
`endif

   int checks   = 0;
   int failures = 0;

   logic [SW-1:0] exp_word [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

   always #5 clk_i = ~clk_i;

   nx_stream_arbiter #(.STREAM_WIDTH(SW), .NUM_DIRS(4), .COUNT_WIDTH(CW)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ib_north_data_i  (n_d),
      .ib_north_valid_i (n_v),
      .ib_north_ready_o (n_r),
      .ib_east_data_i   (e_d),
      .ib_east_valid_i  (e_v),
      .ib_east_ready_o  (e_r),
      .ib_south_data_i  (s_d),
      .ib_south_valid_i (s_v),
      .ib_south_ready_o (s_r),
      .ib_west_data_i   (w_d),
      .ib_west_valid_i  (w_v),
      .ib_west_ready_o  (w_r),
      .arb_data_o       (arb_data_o),
      .arb_dir_o        (arb_dir_o),
      .arb_valid_o      (arb_valid_o),
      .arb_ready_i      (arb_ready_i),
      .idle_o           (idle_o)
`ifdef NX_ARB_STATS_EN
      ,
      .stat_count_o     (stat_count_o)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] data, input logic [31:0] dir);
      check_val({tag, "_valid"}, 32'(arb_valid_o), 32'd1);
      check_val({tag, "_data"}, arb_data_o, data);
      check_val({tag, "_dir"}, 32'(arb_dir_o), dir);
   endtask

   initial begin
      rst_i = 1'b1;
      {n_v, e_v, s_v, w_v} = 4'b0;
      n_d = '0; e_d = '0; s_d = '0; w_d = '0;
      arb_ready_i = 1'b1;

      // Reset state
      step();
      check_val("rst_valid", 32'(arb_valid_o), 32'd0);
      check_val("rst_data", arb_data_o, 32'd0);
      check_val("rst_dir", 32'(arb_dir_o), 32'd0);
      check_val("rst_idle", 32'(idle_o), 32'd1);
      n_v = 1'b1;
      #1;
      check_val("rst_n_ready", 32'(n_r), 32'd0);
      check_val("rst_idle_req", 32'(idle_o), 32'd0);
      step();
      rst_i = 1'b0;

      // All four valid: N,E,S,W then repeat
      n_d = 32'h11; e_d = 32'h22; s_d = 32'h33; w_d = 32'h44;
      {n_v, e_v, s_v, w_v} = 4'b1111;
      #1;
      check_val("rr_first_n_ready", 32'(n_r), 32'd1);
      check_val("rr_first_e_ready", 32'(e_r), 32'd0);
      for (int k = 0; k < 8; k++) begin
         step();
         check_out($sformatf("rr%0d", k), exp_word[k % 4], 32'(k % 4));
      end

      // Drop all valids: slot drains, data holds
      {n_v, e_v, s_v, w_v} = 4'b0;
      step();
      check_val("drain_valid", 32'(arb_valid_o), 32'd0);
      check_val("drain_hold_data", arb_data_o, 32'h44);
      check_val("drain_idle", 32'(idle_o), 32'd1);

      // South only, 8 back-to-back words
      for (int k = 0; k < 8; k++) begin
         s_v = 1'b1;
         s_d = 32'h100 + 32'(k);
         step();
         check_out($sformatf("south%0d", k), 32'h100 + 32'(k), 32'd2);
      end
      s_v = 1'b0;
      step();
      check_val("south_end_valid", 32'(arb_valid_o), 32'd0);

      // Fill slot with 0xAA, stall for 5 cycles with E and W pending
      arb_ready_i = 1'b0;
      n_v = 1'b1; n_d = 32'hAA;
      step();
      check_out("fill", 32'hAA, 32'd0);
      n_v = 1'b0;
      e_v = 1'b1; e_d = 32'hEE;
      w_v = 1'b1; w_d = 32'h77;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_out($sformatf("stall%0d", k), 32'hAA, 32'd0);
         check_val($sformatf("stall%0d_e_ready", k), 32'(e_r), 32'd0);
         check_val($sformatf("stall%0d_w_ready", k), 32'(w_r), 32'd0);
         step();
      end
      arb_ready_i = 1'b1;
      #1;
      check_val("unstall_e_ready", 32'(e_r), 32'd1);
      check_val("unstall_w_ready", 32'(w_r), 32'd0);
      step();
      check_out("unstall_e", 32'hEE, 32'd1);

      // Last grant E; N and W pending -> W first (search starts at S)
      e_v = 1'b0;
      n_v = 1'b1; n_d = 32'h55;
      #1;
      check_val("after_e_w_ready", 32'(w_r), 32'd1);
      check_val("after_e_n_ready", 32'(n_r), 32'd0);
      step();
      check_out("after_e_w", 32'h77, 32'd3);
      step();
      check_out("after_w_n", 32'h55, 32'd0);
      {n_v, e_v, s_v, w_v} = 4'b0;
      step();

      // Async reset with slot full
      n_v = 1'b1; n_d = 32'h99;
      arb_ready_i = 1'b0;
      step();
      check_out("prerst", 32'h99, 32'd0);
      #2;
      rst_i = 1'b1;
      #1;
      check_val("arst_valid", 32'(arb_valid_o), 32'd0);
      check_val("arst_data", arb_data_o, 32'd0);
      check_val("arst_n_ready", 32'(n_r), 32'd0);
      step();
      rst_i = 1'b0;
      n_d = 32'h11; e_d = 32'h22; s_d = 32'h33; w_d = 32'h44;
      {n_v, e_v, s_v, w_v} = 4'b1111;
      arb_ready_i = 1'b1;
      #1;
      check_val("postrst_n_ready", 32'(n_r), 32'd1);
      check_val("postrst_e_ready", 32'(e_r), 32'd0);
      step();
      check_out("postrst_n", 32'h11, 32'd0);

      // North only for 4 more words (5 north accepted since reset)
      {e_v, s_v, w_v} = 3'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check_out($sformatf("nonly%0d", k), 32'h11, 32'd0);
      end
`ifdef NX_ARB_STATS_EN
      check_val("stat_n", 32'(stat_count_o[1:0]), 32'd3);
      check_val("stat_e", 32'(stat_count_o[3:2]), 32'd0);
      check_val("stat_s", 32'(stat_count_o[5:4]), 32'd0);
      check_val("stat_w", 32'(stat_count_o[7:6]), 32'd0);
`endif
      n_v = 1'b0;
      step();
      check_val("final_idle", 32'(idle_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
